// File: rtl/spram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : spram_ctrl_if
// Description : CPU-side request/response bundle of spram_ctrl.
//               master = CPU (drives requests), slave = controller.
//   req_valid/req_ready : request handshake, accepted on valid & ready
//   req_we              : 1 = store, 0 = load
//   req_wmask           : byte-lane enables for stores
//   req_addr            : byte address, [1:0] ignored
//   req_wdata           : lane-aligned store data
//   rsp_valid/rsp_data  : one-cycle load-result pulse, data held afterwards
//   err                 : one-cycle pulse on read timeout
// Revision    : 1.0 - initial release
// ============================================================================
interface spram_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_wmask;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              err;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, err
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, err
  );
endinterface
`default_nettype wire

// File: rtl/spram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spram_ctrl
// Description : Bus-side controller in front of a 32-bit word memory that only
//               writes whole words. Loads issue a single read, full-word stores
//               a single write, partial stores a read-modify-write, and empty
//               stores complete without touching memory. Reads abort after
//               RD_TIMEOUT cycles without rd_valid.
// Ports       :
//   clk          in   single clock, posedge
//   rst_n        in   synchronous active-low reset
//   bus          slave  CPU request/response bundle (spram_ctrl_if)
//   mem_rd_en    out  memory read enable (one-cycle pulse)
//   mem_addr     out  memory byte address, [1:0] always 0
//   mem_rd_data  in   memory read data
//   mem_rd_valid in   memory read data valid
//   mem_wr_en    out  memory write enable (one-cycle pulse)
//   mem_wr_data  out  memory write data
// Configuration macro:
//   SPRAM_CTRL_RDBUF_EN - adds a one-word read buffer; load hits answer the
//                         cycle after accept without a memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int RD_TIMEOUT = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  spram_ctrl_if.slave            bus,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  wire logic [31:0]       mem_rd_data,
  input  wire logic              mem_rd_valid,
  output logic                   mem_wr_en,
  output logic [31:0]            mem_wr_data
);

  localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_WR     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [31:0]       mem_wr_data_q, mem_wr_data_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic [31:0]       merged_word;

`ifdef SPRAM_CTRL_RDBUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-3:0] buf_tag_q, buf_tag_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic              req_tag_hit;
  logic              cur_tag_hit;

  assign req_tag_hit = buf_valid_q && (buf_tag_q == bus.req_addr[ADDR_W-1:2]);
  assign cur_tag_hit = buf_valid_q && (buf_tag_q == mem_addr_q[ADDR_W-1:2]);
`endif

  // req_ready_q is only ever high in IDLE, so it doubles as the idle flag.
  assign accept = bus.req_valid && req_ready_q;

  // Per-lane merge for read-modify-write: masked lanes take store data.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_word[8*i +: 8] = wmask_q[i] ? wdata_q[8*i +: 8]
                                              : mem_rd_data[8*i +: 8];
  end

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    err_d         = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    wmask_d       = wmask_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
`ifdef SPRAM_CTRL_RDBUF_EN
    buf_valid_d   = buf_valid_q;
    buf_tag_d     = buf_tag_q;
    buf_data_d    = buf_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mem_addr_d = bus.req_addr & WORD_MASK;
          wmask_d    = bus.req_wmask;
          wdata_d    = bus.req_wdata;
          if (!bus.req_we) begin
`ifdef SPRAM_CTRL_RDBUF_EN
            if (req_tag_hit) begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = buf_data_q;
            end else begin
              state_d     = S_RD;
              mem_rd_en_d = 1'b1;
              cnt_d       = '0;
            end
`else
            state_d     = S_RD;
            mem_rd_en_d = 1'b1;
            cnt_d       = '0;
`endif
          end else if (bus.req_wmask == 4'hF) begin
            state_d       = S_WR;
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = bus.req_wdata;
`ifdef SPRAM_CTRL_RDBUF_EN
            if (req_tag_hit) buf_data_d = bus.req_wdata;
`endif
          end else if (bus.req_wmask != 4'h0) begin
            state_d     = S_RMW_RD;
            mem_rd_en_d = 1'b1;
            cnt_d       = '0;
          end
          // An empty mask completes in IDLE with no memory access.
        end
      end

      S_RD: begin
        if (mem_rd_valid) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_rd_data;
`ifdef SPRAM_CTRL_RDBUF_EN
          buf_valid_d = 1'b1;
          buf_tag_d   = mem_addr_q[ADDR_W-1:2];
          buf_data_d  = mem_rd_data;
`endif
        end else if (cnt_q == CNT_LAST) begin
          // Abort: the load still completes, returning zero.
          state_d     = S_IDLE;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
`ifdef SPRAM_CTRL_RDBUF_EN
          buf_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RMW_RD: begin
        if (mem_rd_valid) begin
          state_d       = S_RMW_WR;
          mem_wr_en_d   = 1'b1;
          mem_wr_data_d = merged_word;
`ifdef SPRAM_CTRL_RDBUF_EN
          if (cur_tag_hit) buf_data_d = merged_word;
`endif
        end else if (cnt_q == CNT_LAST) begin
          // Abort: the partial store is dropped.
          state_d = S_IDLE;
          err_d   = 1'b1;
`ifdef SPRAM_CTRL_RDBUF_EN
          buf_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RMW_WR: state_d = S_IDLE;
      S_WR:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      err_q         <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      wmask_q       <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
`ifdef SPRAM_CTRL_RDBUF_EN
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= '0;
      buf_data_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      err_q         <= err_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      wmask_q       <= wmask_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
`ifdef SPRAM_CTRL_RDBUF_EN
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign mem_wr_data   = mem_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spram_ctrl
// Description : Directed testbench for spram_ctrl with a behavioural word
//               memory (rd_valid one cycle after rd_en, optional stall).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_ctrl;

  localparam int ADDR_W = 15;

  logic              clk;
  logic              rst_n;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic              mem_rd_valid;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic              stall;

  logic [31:0] mem [0:8191];
  int          rd_cnt;
  int          wr_cnt;
  int          n_cmp;
  int          n_mis;
  int          rd0;
  int          wr0;

  spram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spram_ctrl #(.ADDR_W(ADDR_W), .RD_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: not affected by reset.
  always @(posedge clk) begin
    mem_rd_valid <= mem_rd_en && !stall;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr[14:2]];
      rd_cnt      <= rd_cnt + 1;
    end
    if (mem_wr_en) begin
      mem[mem_addr[14:2]] <= mem_wr_data;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [3:0] mask,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_wmask = mask;
    bus.req_addr  = addr;
    bus.req_wdata = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    stall = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[12] = 32'h1122_3344;   // byte address 0x0030

    // 1: reset held with a pending load request
    rst_n = 1'b0;
    drive_req(1'b0, 4'h0, 15'h0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    tick();
    chk("rst_no_reads", 32'(rd_cnt), 32'd0);

    // 2: full-word store then load of the same word
    drive_req(1'b1, 4'hF, 15'h0010, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = 1'b0;
    chk("st_ready_busy", 32'(bus.req_ready), 32'd0);
    chk("st_wr_en", 32'(mem_wr_en), 32'd1);
    chk("st_wr_data", mem_wr_data, 32'hDEAD_BEEF);
    chk("st_addr", 32'(mem_addr), 32'h10);
    tick();
    chk("st_wr_en_off", 32'(mem_wr_en), 32'd0);
    chk("st_ready_back", 32'(bus.req_ready), 32'd1);
    chk("st_wr_count", 32'(wr_cnt), 32'd1);
    chk("st_rd_count", 32'(rd_cnt), 32'd0);
    drive_req(1'b0, 4'h0, 15'h0012, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("ld_rd_en", 32'(mem_rd_en), 32'd1);
    chk("ld_addr", 32'(mem_addr), 32'h10);
    chk("ld_rsp_early0", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("ld_rsp_early1", 32'(bus.rsp_valid), 32'd0);
    chk("ld_rd_en_off", 32'(mem_rd_en), 32'd0);
    tick();
    chk("ld_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ld_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("ld_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("ld_rsp_hold", bus.rsp_data, 32'hDEAD_BEEF);
    chk("ld_rd_count", 32'(rd_cnt), 32'd1);
`ifdef SPRAM_CTRL_RDBUF_EN
    // Repeat load hits the buffer: answer next cycle, no memory read.
    drive_req(1'b0, 4'h0, 15'h0010, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("hit_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("hit_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
    chk("hit_no_rd_en", 32'(mem_rd_en), 32'd0);
    tick();
`endif

    // 3: partial store via read-modify-write
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_req(1'b1, 4'b0010, 15'h0030, 32'h0000_AA00);
    tick();
    bus.req_valid = 1'b0;
    chk("rmw_rd_en", 32'(mem_rd_en), 32'd1);
    chk("rmw_no_wr_yet", 32'(mem_wr_en), 32'd0);
    tick();
    chk("rmw_wait", 32'(mem_wr_en), 32'd0);
    tick();
    chk("rmw_wr_en", 32'(mem_wr_en), 32'd1);
    chk("rmw_wr_data", mem_wr_data, 32'h1122_AA44);
    chk("rmw_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rmw_ready_back", 32'(bus.req_ready), 32'd1);
    chk("rmw_mem_word", mem[12], 32'h1122_AA44);
    chk("rmw_reads", 32'(rd_cnt - rd0), 32'd1);
    chk("rmw_writes", 32'(wr_cnt - wr0), 32'd1);

    // 4: empty-mask store is a no-op
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_req(1'b1, 4'h0, 15'h0020, 32'hFFFF_FFFF);
    tick();
    bus.req_valid = 1'b0;
    chk("nop_ready", 32'(bus.req_ready), 32'd1);
    chk("nop_rd_en", 32'(mem_rd_en), 32'd0);
    chk("nop_wr_en", 32'(mem_wr_en), 32'd0);
    tick();
    tick();
    chk("nop_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("nop_writes", 32'(wr_cnt - wr0), 32'd0);

    // 5: read timeout
    stall = 1'b1;
    drive_req(1'b0, 4'h0, 15'h0040, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("to_rd_en", 32'(mem_rd_en), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_err_early", 32'(bus.err), 32'd0);
      chk("to_busy", 32'(bus.req_ready), 32'd0);
    end
    tick();
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_data", bus.rsp_data, 32'h0);
    tick();
    chk("to_err_pulse", 32'(bus.err), 32'd0);
    chk("to_ready_back", 32'(bus.req_ready), 32'd1);
    stall = 1'b0;

    // 6: reset during RMW read phase drops the write
    wr0 = wr_cnt;
    drive_req(1'b1, 4'b0001, 15'h0030, 32'h0000_00FF);
    tick();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("mid_rst_wr_en2", 32'(mem_wr_en), 32'd0);
    tick();
    chk("mid_rst_writes", 32'(wr_cnt - wr0), 32'd0);
    drive_req(1'b0, 4'h0, 15'h0030, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("mid_rst_ld_valid", 32'(bus.rsp_valid), 32'd1);
    chk("mid_rst_ld_data", bus.rsp_data, 32'h1122_AA44);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
